// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter that shares one I2C master command port between NREQ
// requesters, tracks the master's busy/done handshake and returns the response.
module i2c_req_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 200000,
  parameter int ISSUE_MAX   = 16,
  parameter int PTR_W       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ-1:0]   req_op,
  input  logic [7*NREQ-1:0] req_addr,
  input  logic [8*NREQ-1:0] req_din,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [7:0]        rsp_dout,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              m_newd,
  output logic              m_op,
  output logic [6:0]        m_addr,
  output logic [7:0]        m_din,
  input  logic [7:0]        m_dout,
  input  logic              m_busy,
  input  logic              m_ack_err,
  input  logic              m_done
);

  // Handshake: a requester holds req and its command until gnt rises; rsp_valid
  // is a one-cycle pulse with no back-pressure. Toward the master, m_newd is held
  // until m_busy is sampled high and completion is the rising edge of m_done.

  localparam int CNT_MAX = (TIMEOUT_CYC > ISSUE_MAX) ? TIMEOUT_CYC : ISSUE_MAX;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, RESP} state_t;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win_q;
  logic [CNT_W-1:0] cnt;
  logic             done_d;
  logic             done_rise;

  logic [NREQ-1:0]  rot;
  logic [PTR_W-1:0] off;
  logic [PTR_W:0]   sum;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic             pick_op;
  logic [6:0]       pick_addr;
  logic [7:0]       pick_din;

  assign done_rise = m_done & ~done_d;

  // Rotate the request vector so the pointer lands on bit 0, take the lowest set
  // bit, then rotate the offset back to an absolute index.
  always_comb begin
    rot        = NREQ'({req, req} >> ptr);
    pick_found = |rot;
    off        = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = PTR_W'(k);
    end
    sum = {1'b0, ptr} + {1'b0, off};
    if (sum >= (PTR_W+1)'(NREQ)) sum = sum - (PTR_W+1)'(NREQ);
    pick_idx  = sum[PTR_W-1:0];
    pick_op   = 1'b0;
    pick_addr = '0;
    pick_din  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PTR_W'(i)) begin
        pick_op   = req_op[i];
        pick_addr = req_addr[7*i +: 7];
        pick_din  = req_din[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      ptr         <= '0;
      win_q       <= '0;
      cnt         <= '0;
      done_d      <= 1'b0;
      gnt         <= '0;
      rsp_valid   <= '0;
      rsp_dout    <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      m_newd      <= 1'b0;
      m_op        <= 1'b0;
      m_addr      <= '0;
      m_din       <= '0;
    end else begin
      done_d <= m_done;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt    <= NREQ'(1) << pick_idx;
            win_q  <= pick_idx;
            m_op   <= pick_op;
            m_addr <= pick_addr;
            m_din  <= pick_din;
            m_newd <= 1'b1;
            cnt    <= '0;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          cnt <= cnt + CNT_W'(1);
          if (m_busy) begin
            m_newd <= 1'b0;
            state  <= WAIT_DONE;
          end else if (cnt == CNT_W'(ISSUE_MAX - 1)) begin
            // Master never accepted the command: abort without touching the bus.
            m_newd      <= 1'b0;
            rsp_dout    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= gnt;
            state       <= RESP;
          end
        end
        WAIT_DONE: begin
          cnt <= cnt + CNT_W'(1);
          if (done_rise) begin
            rsp_dout    <= m_dout;
            rsp_err     <= m_ack_err;
            rsp_timeout <= 1'b0;
            rsp_valid   <= gnt;
            state       <= RESP;
          end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
            rsp_dout    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b1;
            rsp_valid   <= gnt;
            state       <= RESP;
          end
        end
        RESP: begin
          ptr         <= (win_q == PTR_W'(NREQ - 1)) ? '0 : win_q + PTR_W'(1);
          gnt         <= '0;
          rsp_valid   <= '0;
          rsp_timeout <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt));
  a_rsp_in_gnt: assert property (@(posedge clk) disable iff (!rst) ((rsp_valid & ~gnt) == '0));

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Directed bench for i2c_req_arbiter: a behavioural master, grant and response
// scoreboards, and a second instance with a short transaction timeout.
module tb_i2c_req_arbiter;

  localparam int W = 4 + 8 + 1 + 1;

  logic        clk, rst;
  logic [3:0]  req, req_op;
  logic [27:0] req_addr;
  logic [31:0] req_din;
  logic [3:0]  gnt, rsp_valid;
  logic [7:0]  rsp_dout;
  logic        rsp_err, rsp_timeout, m_newd, m_op;
  logic [6:0]  m_addr;
  logic [7:0]  m_din;
  logic [7:0]  m_dout;
  logic        m_busy, m_ack_err, m_done;

  logic [3:0]  gnt_t, rsp_valid_t;
  logic [7:0]  rsp_dout_t;
  logic        rsp_err_t, rsp_timeout_t, m_newd_t, m_op_t;
  logic [6:0]  m_addr_t;
  logic [7:0]  m_din_t;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];
  logic [3:0]   gnt_q[$];
  logic [3:0]   gnt_prev = '0;

  int         mm_done_lat = 4;
  logic [7:0] mm_dout     = '0;
  logic       mm_err      = 1'b0;
  logic       mm_dead     = 1'b0;
  logic       mm_abort    = 1'b0;

  i2c_req_arbiter #(.NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_din(req_din), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_dout(rsp_dout),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .m_newd(m_newd), .m_op(m_op),
    .m_addr(m_addr), .m_din(m_din), .m_dout(m_dout), .m_busy(m_busy),
    .m_ack_err(m_ack_err), .m_done(m_done)
  );

  i2c_req_arbiter #(.NREQ(4), .TIMEOUT_CYC(500)) dut_t (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .req_addr(req_addr),
    .req_din(req_din), .gnt(gnt_t), .rsp_valid(rsp_valid_t), .rsp_dout(rsp_dout_t),
    .rsp_err(rsp_err_t), .rsp_timeout(rsp_timeout_t), .m_newd(m_newd_t), .m_op(m_op_t),
    .m_addr(m_addr_t), .m_din(m_din_t), .m_dout(m_dout), .m_busy(m_busy),
    .m_ack_err(m_ack_err), .m_done(m_done)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // behavioural master: busy after newd, done (level) after mm_done_lat cycles
  initial begin
    int k;
    m_busy = 1'b0; m_done = 1'b0; m_dout = '0; m_ack_err = 1'b0;
    forever begin
      @(negedge clk);
      if (m_newd && !m_busy && !mm_dead) begin
        m_busy = 1'b1;
        m_done = 1'b0;
        k = 0;
        while (k < mm_done_lat && !mm_abort) begin
          @(negedge clk);
          k++;
        end
        m_busy = 1'b0;
        if (mm_abort) begin
          m_done   = 1'b0;
          mm_abort = 1'b0;
        end else begin
          m_dout    = mm_dout;
          m_ack_err = mm_err;
          m_done    = 1'b1;
        end
      end
    end
  end

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst) begin
      if (gnt != 4'b0 && gnt_prev == 4'b0) begin
        if (gnt_q.size() == 0) chk("gnt_unexpected", 32'(gnt), 0);
        else                   chk("gnt_order", 32'(gnt), 32'(gnt_q.pop_front()));
      end
      if (rsp_valid != 4'b0) begin
        if (exp_q.size() == 0) chk("rsp_unexpected", 32'(rsp_valid), 0);
        else chk("rsp", 32'({rsp_valid, rsp_dout, rsp_err, rsp_timeout}), 32'(exp_q.pop_front()));
      end
    end
    gnt_prev = gnt;
  end

  // driver tasks
  task automatic set_req(input int idx, input logic op, input logic [6:0] a, input logic [7:0] d);
    req[idx]             = 1'b1;
    req_op[idx]          = op;
    req_addr[7*idx +: 7] = a;
    req_din[8*idx +: 8]  = d;
  endtask

  task automatic wait_any_gnt(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (gnt == 4'b0 && n < bound);
    if (gnt == 4'b0) chk("gnt_wait_timeout", 32'(gnt), 1);
  endtask

  task automatic wait_rsp(input int bound);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid == 4'b0 && n < bound);
    if (rsp_valid == 4'b0) chk("rsp_wait_timeout", 32'(rsp_valid), 1);
  endtask

  task automatic serve(input int count);
    for (int i = 0; i < count; i++) begin
      wait_any_gnt(100);
      req = req & ~gnt;
      wait_rsp(1000);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_dout"}, 32'(rsp_dout), 0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    chk({tag, "_m_newd"}, 32'(m_newd), 0);
    chk({tag, "_m_op"}, 32'(m_op), 0);
    chk({tag, "_m_addr"}, 32'(m_addr), 0);
    chk({tag, "_m_din"}, 32'(m_din), 0);
  endtask

  initial begin
    int n;
    rst = 1'b0; req = '0; req_op = '0; req_addr = '0; req_din = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    // single write by requester 2, master done after 300 cycles
    mm_done_lat = 300; mm_dout = 8'h00; mm_err = 1'b0;
    gnt_q.push_back(4'b0100);
    exp_q.push_back({4'b0100, 8'h00, 1'b0, 1'b0});
    rst = 1'b1;
    set_req(2, 1'b0, 7'h05, 8'h03);
    @(negedge clk);
    chk("t1_gnt_latency", 32'(gnt), 4);
    chk("t1_m_newd", 32'(m_newd), 1);
    chk("t1_m_addr", 32'(m_addr), 5);
    chk("t1_m_din", 32'(m_din), 3);
    chk("t1_m_op", 32'(m_op), 0);
    req[2] = 1'b0;
    wait_rsp(1000);
    @(negedge clk);
    chk("t1_rsp_pulse", 32'(rsp_valid), 0);
    chk("t1_gnt_release", 32'(gnt), 0);

    // pointer is 3: requests 0,2,3 are served as 3,0,2
    mm_done_lat = 5; mm_dout = 8'h77;
    set_req(0, 1'b0, 7'h10, 8'h11);
    set_req(2, 1'b0, 7'h12, 8'h22);
    set_req(3, 1'b1, 7'h13, 8'h33);
    gnt_q.push_back(4'b1000); gnt_q.push_back(4'b0001); gnt_q.push_back(4'b0100);
    exp_q.push_back({4'b1000, 8'h77, 1'b0, 1'b0});
    exp_q.push_back({4'b0001, 8'h77, 1'b0, 1'b0});
    exp_q.push_back({4'b0100, 8'h77, 1'b0, 1'b0});
    serve(3);

    // read by requester 1 with an ack error
    mm_dout = 8'hA5; mm_err = 1'b1;
    gnt_q.push_back(4'b0010);
    exp_q.push_back({4'b0010, 8'hA5, 1'b1, 1'b0});
    @(negedge clk);
    set_req(1, 1'b1, 7'h09, 8'hEE);
    @(negedge clk);
    chk("rd_gnt", 32'(gnt), 2);
    chk("rd_m_op", 32'(m_op), 1);
    chk("rd_m_addr", 32'(m_addr), 9);
    req[1] = 1'b0;
    wait_rsp(100);
    chk("rd_rsp_timeout", 32'(rsp_timeout), 0);

    // clock stretch: 1200 cycles completes normally, short-timeout copy aborts at 500
    mm_done_lat = 1200; mm_dout = 8'h5A; mm_err = 1'b0;
    gnt_q.push_back(4'b0001);
    exp_q.push_back({4'b0001, 8'h5A, 1'b0, 1'b0});
    @(negedge clk);
    set_req(0, 1'b0, 7'h22, 8'h44);
    @(negedge clk);
    chk("st_gnt", 32'(gnt), 1);
    req[0] = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (rsp_valid_t == 4'b0 && n < 2000);
    chk("to_latency", n, 500);
    chk("to_rsp_valid", 32'(rsp_valid_t), 1);
    chk("to_rsp_timeout", 32'(rsp_timeout_t), 1);
    chk("to_rsp_dout", 32'(rsp_dout_t), 0);
    chk("to_rsp_err", 32'(rsp_err_t), 0);
    chk("st_still_waiting", 32'(rsp_valid), 0);
    wait_rsp(2000);
    chk("st_rsp_timeout", 32'(rsp_timeout), 0);

    // master never goes busy: m_newd held exactly ISSUE_MAX cycles
    mm_dead = 1'b1; mm_done_lat = 5;
    gnt_q.push_back(4'b0100);
    exp_q.push_back({4'b0100, 8'h00, 1'b0, 1'b1});
    @(negedge clk);
    set_req(2, 1'b0, 7'h2A, 8'h55);
    @(negedge clk);
    req[2] = 1'b0;
    n = 0;
    while (m_newd && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("issue_newd_cycles", n, 16);
    chk("issue_rsp_timeout", 32'(rsp_timeout), 1);
    chk("issue_rsp_valid", 32'(rsp_valid), 4);
    @(negedge clk);
    chk("issue_idle_gnt", 32'(gnt), 0);
    chk("issue_timeout_clear", 32'(rsp_timeout), 0);
    mm_dead = 1'b0;

    // reset during WAIT_DONE of requester 3; pointer returns to 0
    mm_done_lat = 100;
    gnt_q.push_back(4'b1000);
    set_req(3, 1'b1, 7'h33, 8'h66);
    @(negedge clk);
    req[3] = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_in_wait", 32'(m_newd), 0);
    set_req(0, 1'b0, 7'h01, 8'h10);
    set_req(3, 1'b0, 7'h03, 8'h30);
    rst = 1'b0;
    mm_abort = 1'b1;
    @(negedge clk);
    chk_all_zero("midrst");
    mm_done_lat = 5; mm_dout = 8'h33;
    gnt_q.push_back(4'b0001); gnt_q.push_back(4'b1000);
    exp_q.push_back({4'b0001, 8'h33, 1'b0, 1'b0});
    exp_q.push_back({4'b1000, 8'h33, 1'b0, 1'b0});
    rst = 1'b1;
    serve(2);

    // all four held continuously from reset: order 0,1,2,3,0, one idle cycle between
    mm_dout = 8'h3C; mm_done_lat = 4;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_req(i, i[0], 7'(i + 1), 8'(i * 16));
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      gnt_q.push_back(4'b0001 << (i % 4));
      exp_q.push_back({4'(4'b0001 << (i % 4)), 8'h3C, 1'b0, 1'b0});
    end
    rst = 1'b1;
    wait_any_gnt(10);
    for (int i = 0; i < 5; i++) begin
      wait_rsp(100);
      if (i == 4) req = '0;
      @(negedge clk);
      chk("rr_idle_gap", 32'(gnt), 0);
      if (i < 4) begin
        @(negedge clk);
        chk("rr_regrant", 32'(gnt != 4'b0), 1);
      end
    end

    repeat (5) @(negedge clk);
    chk("gnt_queue_empty", gnt_q.size(), 0);
    chk("rsp_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
